l2_req_responder: RTL and testbench

L2_REQ_RESPONDER -- requirements
Module: l2_req_responder

---
 rtl/l2_req_responder_pkg.sv | 85 ++++++++
 rtl/l2_req_responder_if.sv | 21 ++
 rtl/l2_req_responder_mem.sv | 29 ++
 rtl/l2_req_responder.sv | 117 +++++++++++
 tb/tb_l2_req_responder.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/l2_req_responder_pkg.sv
// Shared coherence constants and types for the L2 request responder.
// The state enum drops WAIT unless L2_REQ_RESPONDER_DELAY_EN is defined.
package l2_req_responder_pkg;

  localparam int WORDS_PER_LINE = 4;
  localparam int WORD_BITS      = 32;
  localparam int ADDR_BITS      = 32;
  localparam int COH_MSG_BITS   = 3;

  typedef logic [COH_MSG_BITS-1:0]              coh_msg_t;
  typedef logic [WORDS_PER_LINE*WORD_BITS-1:0]  line_t;
  typedef logic [WORDS_PER_LINE-1:0]            word_mask_t;
  typedef logic [ADDR_BITS-1:0]                 line_addr_t;
  typedef logic [1:0]                           hprot_t;
  typedef logic [3:0]                           invack_cnt_t;

  // Codes 6 and 7 are deliberately unassigned and count as unsupported.
  localparam coh_msg_t REQ_S     = 3'd0;
  localparam coh_msg_t REQ_O     = 3'd1;
  localparam coh_msg_t REQ_V     = 3'd2;
  localparam coh_msg_t REQ_Odata = 3'd3;
  localparam coh_msg_t REQ_WT    = 3'd4;
  localparam coh_msg_t REQ_WB    = 3'd5;

  localparam coh_msg_t RSP_S      = 3'd0;
  localparam coh_msg_t RSP_O      = 3'd1;
  localparam coh_msg_t RSP_V      = 3'd2;
  localparam coh_msg_t RSP_Odata  = 3'd3;
  localparam coh_msg_t RSP_WT     = 3'd4;
  localparam coh_msg_t RSP_WB_ACK = 3'd5;

  typedef struct packed {
    coh_msg_t   coh_msg;
    hprot_t     hprot;
    line_addr_t addr;
    line_t      line;
    word_mask_t word_mask;
  } l2_req_out_t;

  typedef struct packed {
    coh_msg_t    coh_msg;
    line_addr_t  addr;
    line_t       line;
    word_mask_t  word_mask;
    invack_cnt_t invack_cnt;
  } l2_rsp_in_t;

`ifdef L2_REQ_RESPONDER_DELAY_EN
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, SEND} state_t;
`else
  typedef enum logic [1:0] {IDLE, ACCESS, SEND} state_t;
`endif

  function automatic logic is_supported(input coh_msg_t msg);
    return (msg <= REQ_WB);
  endfunction

  function automatic logic is_write(input coh_msg_t msg);
    return (msg == REQ_WT) || (msg == REQ_WB);
  endfunction

  function automatic coh_msg_t rsp_msg(input coh_msg_t msg);
    coh_msg_t rsp;
    case (msg)
      REQ_O:     rsp = RSP_O;
      REQ_V:     rsp = RSP_V;
      REQ_Odata: rsp = RSP_Odata;
      REQ_WT:    rsp = RSP_WT;
      REQ_WB:    rsp = RSP_WB_ACK;
      default:   rsp = RSP_S;
    endcase
    return rsp;
  endfunction

  function automatic line_t merge_line(input line_t old_line, input line_t new_line,
                                       input word_mask_t mask);
    line_t merged;
    merged = old_line;
    for (int w = 0; w < WORDS_PER_LINE; w++) begin
      if (mask[w]) merged[w*WORD_BITS +: WORD_BITS] = new_line[w*WORD_BITS +: WORD_BITS];
    end
    return merged;
  endfunction

endpackage

// File: rtl/l2_req_responder_if.sv
// Request/response handshake bundle between an L2 (master) and the responder (slave).
interface l2_req_responder_if;
  import l2_req_responder_pkg::*;

  logic        l2_req_out_valid;
  logic        l2_req_out_ready;
  l2_req_out_t l2_req_out;
  logic        l2_rsp_in_valid;
  logic        l2_rsp_in_ready;
  l2_rsp_in_t  l2_rsp_in;

  modport master (
    output l2_req_out_valid, l2_req_out, l2_rsp_in_ready,
    input  l2_req_out_ready, l2_rsp_in_valid, l2_rsp_in
  );

  modport slave (
    input  l2_req_out_valid, l2_req_out, l2_rsp_in_ready,
    output l2_req_out_ready, l2_rsp_in_valid, l2_rsp_in
  );
endinterface

// File: rtl/l2_req_responder_mem.sv
// Backing line store: word-masked write port, combinational read port, cleared on reset.
module l2_req_responder_mem
  import l2_req_responder_pkg::*;
#(
  parameter  int MEM_LINES = 16,
  localparam int IDX_W     = $clog2(MEM_LINES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] idx,
  input  word_mask_t       wr_mask,
  input  line_t            wr_line,
  output line_t            rd_line
);

  line_t lines [MEM_LINES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MEM_LINES; i++) lines[i] <= '0;
    end else if (wr_en) begin
      lines[idx] <= merge_line(lines[idx], wr_line, wr_mask);
    end
  end

  assign rd_line = lines[idx];

endmodule

// File: rtl/l2_req_responder.sv
// Single-outstanding L2 request responder backed by a small line memory.
// Define L2_REQ_RESPONDER_DELAY_EN to insert RSP_DELAY wait cycles before each response.
module l2_req_responder
  import l2_req_responder_pkg::*;
#(
  parameter int MEM_LINES = 16,
  parameter int RSP_DELAY = 4
) (
  input  logic                clk,
  input  logic                rst,
  l2_req_responder_if.slave   bus,
  output logic                err_unsupported
);

  localparam int IDX_W = $clog2(MEM_LINES);

  state_t      state, state_next;
  logic        ready_q;
  logic        rsp_valid;
  logic        req_hs;
  logic        supported;
  logic        mem_we;
  l2_req_out_t req_q;
  l2_rsp_in_t  rsp_q;
  line_t       rd_line;
  line_t       post_line;
  logic        unused_hprot;

`ifdef L2_REQ_RESPONDER_DELAY_EN
  logic [7:0]  delay_cnt;
`else
  logic [7:0]  unused_rsp_delay;
  assign unused_rsp_delay = 8'(RSP_DELAY);
`endif

  assign req_hs       = bus.l2_req_out_valid & ready_q;
  assign supported    = is_supported(req_q.coh_msg);
  assign mem_we       = (state == ACCESS) & is_write(req_q.coh_msg);
  assign post_line    = mem_we ? merge_line(rd_line, req_q.line, req_q.word_mask) : rd_line;
  assign unused_hprot = ^req_q.hprot;

  l2_req_responder_mem #(.MEM_LINES(MEM_LINES)) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (mem_we),
    .idx     (req_q.addr[IDX_W-1:0]),
    .wr_mask (req_q.word_mask),
    .wr_line (req_q.line),
    .rd_line (rd_line)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    rsp_valid  = 1'b0;
    unique case (state)
      IDLE:   if (req_hs) state_next = ACCESS;
      ACCESS: begin
        if (!supported) state_next = IDLE;
`ifdef L2_REQ_RESPONDER_DELAY_EN
        else            state_next = WAIT;
`else
        else            state_next = SEND;
`endif
      end
`ifdef L2_REQ_RESPONDER_DELAY_EN
      WAIT:   if (delay_cnt == 8'd0) state_next = SEND;
`endif
      SEND: begin
        rsp_valid = 1'b1;
        if (bus.l2_rsp_in_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Ready is registered so it stays low through reset and rises on the first edge after it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q         <= 1'b0;
      req_q           <= '0;
      rsp_q           <= '0;
      err_unsupported <= 1'b0;
    end else begin
      ready_q <= (state_next == IDLE);
      if (req_hs) req_q <= bus.l2_req_out;
      if (state == ACCESS) begin
        if (supported) begin
          rsp_q.coh_msg    <= rsp_msg(req_q.coh_msg);
          rsp_q.addr       <= req_q.addr;
          rsp_q.line       <= post_line;
          rsp_q.word_mask  <= (req_q.coh_msg == REQ_S) ? '1 : req_q.word_mask;
          rsp_q.invack_cnt <= '0;
        end else begin
          err_unsupported <= 1'b1;
        end
      end
    end
  end

`ifdef L2_REQ_RESPONDER_DELAY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                     delay_cnt <= 8'd0;
    else if (state == ACCESS)                     delay_cnt <= 8'(RSP_DELAY - 1);
    else if (state == WAIT && delay_cnt != 8'd0)  delay_cnt <= delay_cnt - 8'd1;
  end
`endif

  assign bus.l2_req_out_ready = ready_q;
  assign bus.l2_rsp_in_valid  = rsp_valid;
  assign bus.l2_rsp_in        = rsp_q;

endmodule

// File: tb/tb_l2_req_responder.sv
// Bench for l2_req_responder: directed vector table, randomized requests against a line-memory model,
// and reset-during-transaction sequences. Honours L2_REQ_RESPONDER_DELAY_EN for expected latency.
module tb_l2_req_responder;
  import l2_req_responder_pkg::*;

  localparam int MEM_LINES = 16;
  localparam int RSP_DELAY = 4;
`ifdef L2_REQ_RESPONDER_DELAY_EN
  localparam int EXP_LAT = 2 + RSP_DELAY;
`else
  localparam int EXP_LAT = 2;
`endif
  localparam int LAT_BOUND = EXP_LAT + 12;
  localparam int NV = 10;

  typedef struct {
    coh_msg_t   msg;
    line_addr_t addr;
    line_t      line;
    word_mask_t mask;
    int         hold;
    bit         exp_has;
    coh_msg_t   exp_msg;
    line_t      exp_line;
    word_mask_t exp_mask;
    bit         chk_line;
    bit         exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic err_unsupported;
  int   tests_run = 0;
  int   tests_failed = 0;

  line_t model_mem [MEM_LINES];
  bit    model_err;

  l2_req_responder_if bus ();

  l2_req_responder #(.MEM_LINES(MEM_LINES), .RSP_DELAY(RSP_DELAY)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .err_unsupported (err_unsupported)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [191:0] act, input logic [191:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < MEM_LINES; i++) model_mem[i] = '0;
    model_err = 1'b0;
  endfunction

  // Reference behaviour: one line per index, masked word writes, response from the updated line.
  function automatic void model_apply(input l2_req_out_t r, output bit has, output l2_rsp_in_t e);
    int idx;
    e   = '0;
    has = 1'b1;
    idx = int'(r.addr % MEM_LINES);
    case (r.coh_msg)
      REQ_S:     e.coh_msg = RSP_S;
      REQ_O:     e.coh_msg = RSP_O;
      REQ_V:     e.coh_msg = RSP_V;
      REQ_Odata: e.coh_msg = RSP_Odata;
      REQ_WT:    e.coh_msg = RSP_WT;
      REQ_WB:    e.coh_msg = RSP_WB_ACK;
      default:   has = 1'b0;
    endcase
    if (!has) begin
      model_err = 1'b1;
      return;
    end
    if (r.coh_msg == REQ_WT || r.coh_msg == REQ_WB) begin
      for (int w = 0; w < 4; w++)
        if (r.word_mask[w]) model_mem[idx][w*32 +: 32] = r.line[w*32 +: 32];
    end
    e.addr      = r.addr;
    e.line      = model_mem[idx];
    e.word_mask = (r.coh_msg == REQ_S) ? 4'hF : r.word_mask;
  endfunction

  function automatic l2_rsp_in_t mask_line(input l2_rsp_in_t r, input bit chk);
    l2_rsp_in_t m;
    m = r;
    if (!chk) m.line = '0;
    return m;
  endfunction

  function automatic vec_t mk_vec(input coh_msg_t msg, input line_addr_t addr, input line_t line,
                                  input word_mask_t mask, input int hold, input bit exp_has,
                                  input coh_msg_t exp_msg, input line_t exp_line,
                                  input word_mask_t exp_mask, input bit chk_line, input bit exp_err);
    vec_t v;
    v.msg = msg; v.addr = addr; v.line = line; v.mask = mask; v.hold = hold;
    v.exp_has = exp_has; v.exp_msg = exp_msg; v.exp_line = exp_line;
    v.exp_mask = exp_mask; v.chk_line = chk_line; v.exp_err = exp_err;
    return v;
  endfunction

  // Starts and ends on a falling edge; holds rsp ready low for 'hold' cycles once valid appears.
  task automatic applyStimulus(input l2_req_out_t req, input int hold, input bit exp_has,
                               input l2_rsp_in_t exp, input bit chk_line,
                               output bit seen, output l2_rsp_in_t got, output int lat);
    int n = 0;
    seen = 1'b0;
    got  = '0;
    lat  = 0;
    bus.l2_req_out       = req;
    bus.l2_req_out_valid = 1'b1;
    bus.l2_rsp_in_ready  = 1'b0;
    while (!bus.l2_req_out_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.l2_req_out_ready) begin
      checkOutput("req_ready_timeout", 192'(0), 192'(1));
      bus.l2_req_out_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.l2_req_out_valid = 1'b0;
    bus.l2_req_out       = '0;
    lat = 1;
    while (lat < LAT_BOUND && !bus.l2_rsp_in_valid) begin
      if (exp_has) checkOutput("req_ready_busy", 192'(bus.l2_req_out_ready), 192'(0));
      @(negedge clk);
      lat++;
    end
    seen = bus.l2_rsp_in_valid;
    if (!seen) return;
    got = bus.l2_rsp_in;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput("rsp_valid_hold", 192'(bus.l2_rsp_in_valid), 192'(1));
      checkOutput("rsp_fields_hold", 192'(mask_line(bus.l2_rsp_in, chk_line)),
                  192'(mask_line(exp, chk_line)));
      checkOutput("req_ready_in_send", 192'(bus.l2_req_out_ready), 192'(0));
    end
    bus.l2_rsp_in_ready = 1'b1;
    @(negedge clk);
    bus.l2_rsp_in_ready = 1'b0;
  endtask

  task automatic run_request(input string tag, input l2_req_out_t req, input int hold);
    bit         exp_has, seen, chk_line;
    l2_rsp_in_t exp, got;
    int         lat;
    model_apply(req, exp_has, exp);
    chk_line = req.coh_msg inside {REQ_V, REQ_S, REQ_Odata};
    applyStimulus(req, hold, exp_has, exp, chk_line, seen, got, lat);
    checkOutput({tag, "_rsp_seen"}, 192'(seen), 192'(exp_has));
    if (exp_has && seen) begin
      checkOutput({tag, "_latency"}, 192'(lat), 192'(EXP_LAT));
      checkOutput({tag, "_rsp"}, 192'(mask_line(got, chk_line)), 192'(mask_line(exp, chk_line)));
    end
    checkOutput({tag, "_err"}, 192'(err_unsupported), 192'(model_err));
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t        vecs [NV];
    l2_req_out_t req;
    l2_rsp_in_t  exp, got, model_rsp;
    bit          seen, model_has;
    int          lat, n;

    vecs[0] = mk_vec(REQ_S,     32'h80, '0, 4'h0, 0, 1, RSP_S,      '0, 4'hF, 1, 0);
    vecs[1] = mk_vec(REQ_WT,    32'h40, {96'h0, 32'hDEADBEEF}, 4'h1, 0, 1, RSP_WT, '0, 4'h1, 0, 0);
    vecs[2] = mk_vec(REQ_V,     32'h40, '0, 4'h1, 5, 1, RSP_V, {96'h0, 32'hDEADBEEF}, 4'h1, 1, 0);
    vecs[3] = mk_vec(REQ_WT,    32'h41, {4{32'h11}}, 4'hF, 0, 1, RSP_WT, '0, 4'hF, 0, 0);
    vecs[4] = mk_vec(REQ_WB,    32'h41, {4{32'h22}}, 4'h6, 0, 1, RSP_WB_ACK, '0, 4'h6, 0, 0);
    vecs[5] = mk_vec(REQ_Odata, 32'h41, '0, 4'hF, 0, 1, RSP_Odata,
                     {32'h11, 32'h22, 32'h22, 32'h11}, 4'hF, 1, 0);
    vecs[6] = mk_vec(REQ_O,     32'h41, '0, 4'h3, 2, 1, RSP_O, '0, 4'h3, 0, 0);
    vecs[7] = mk_vec(3'd7,      32'h41, {4{32'h99}}, 4'hF, 0, 0, RSP_S, '0, 4'h0, 0, 1);
    vecs[8] = mk_vec(REQ_V,     32'h41, '0, 4'hA, 0, 1, RSP_V,
                     {32'h11, 32'h22, 32'h22, 32'h11}, 4'hA, 1, 1);
    vecs[9] = mk_vec(3'd6,      32'h40, {4{32'h77}}, 4'hF, 0, 0, RSP_S, '0, 4'h0, 0, 1);

    rst                  = 1'b0;
    bus.l2_req_out_valid = 1'b0;
    bus.l2_req_out       = '0;
    bus.l2_rsp_in_ready  = 1'b0;
    model_reset();

    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_req_ready", 192'(bus.l2_req_out_ready), 192'(0));
    checkOutput("reset_rsp_valid", 192'(bus.l2_rsp_in_valid), 192'(0));
    checkOutput("reset_rsp_fields", 192'(bus.l2_rsp_in), 192'(0));
    checkOutput("reset_err", 192'(err_unsupported), 192'(0));
    rst = 1'b1;
    @(negedge clk);
    checkOutput("reset_ready_rise", 192'(bus.l2_req_out_ready), 192'(1));

    for (int i = 0; i < NV; i++) begin
      req = '{coh_msg: vecs[i].msg, hprot: 2'b01, addr: vecs[i].addr,
              line: vecs[i].line, word_mask: vecs[i].mask};
      exp = '{coh_msg: vecs[i].exp_msg, addr: vecs[i].addr, line: vecs[i].exp_line,
              word_mask: vecs[i].exp_mask, invack_cnt: '0};
      model_apply(req, model_has, model_rsp);
      applyStimulus(req, vecs[i].hold, vecs[i].exp_has, exp, vecs[i].chk_line, seen, got, lat);
      checkOutput($sformatf("vec%0d_seen", i), 192'(seen), 192'(vecs[i].exp_has));
      if (vecs[i].exp_has && seen) begin
        checkOutput($sformatf("vec%0d_latency", i), 192'(lat), 192'(EXP_LAT));
        checkOutput($sformatf("vec%0d_rsp", i), 192'(mask_line(got, vecs[i].chk_line)),
                    192'(mask_line(exp, vecs[i].chk_line)));
      end
      checkOutput($sformatf("vec%0d_err", i), 192'(err_unsupported), 192'(vecs[i].exp_err));
    end

    for (int i = 0; i < 40; i++) begin
      req.coh_msg   = coh_msg_t'($urandom_range(0, 7));
      req.hprot     = 2'($urandom);
      req.addr      = ($urandom & 32'hFFFF_FFF0) | 32'($urandom_range(0, 3));
      req.line      = {$urandom, $urandom, $urandom, $urandom};
      req.word_mask = 4'($urandom);
      run_request($sformatf("rnd%0d", i), req, int'($urandom_range(0, 2)));
    end

    // Reset lands mid-transaction: the pending response must vanish and memory must clear.
    req = '{coh_msg: REQ_WT, hprot: 2'b00, addr: 32'h43, line: {4{32'h55}}, word_mask: 4'hF};
    bus.l2_req_out       = req;
    bus.l2_req_out_valid = 1'b1;
    bus.l2_rsp_in_ready  = 1'b0;
    n = 0;
    while (!bus.l2_req_out_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("pulse_req_accept", 192'(bus.l2_req_out_ready), 192'(1));
    @(negedge clk);
    bus.l2_req_out_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("pulse_valid_drop", 192'(bus.l2_rsp_in_valid), 192'(0));
    checkOutput("pulse_ready_low", 192'(bus.l2_req_out_ready), 192'(0));
    checkOutput("pulse_rsp_fields", 192'(bus.l2_rsp_in), 192'(0));
    checkOutput("pulse_err_clear", 192'(err_unsupported), 192'(0));
    @(negedge clk);
    checkOutput("pulse_valid_in_reset", 192'(bus.l2_rsp_in_valid), 192'(0));
    rst = 1'b1;
    @(negedge clk);
    checkOutput("pulse_ready_rise", 192'(bus.l2_req_out_ready), 192'(1));
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("pulse_no_valid%0d", i), 192'(bus.l2_rsp_in_valid), 192'(0));
      @(negedge clk);
    end
    model_reset();
    run_request("post_rst_read",
                '{coh_msg: REQ_V, hprot: 2'b00, addr: 32'h43, line: '0, word_mask: 4'hF}, 0);
    run_request("post_rst_s",
                '{coh_msg: REQ_S, hprot: 2'b00, addr: 32'h40, line: '0, word_mask: 4'h2}, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
